// File: rtl/k7_loader.sv
// rtl/k7_loader.sv - stages HPS ioctl tape bytes into SDRAM and publishes length/valid.
// Define K7_LOADER_CSUM_EN to accumulate a modulo-256 checksum of written bytes on csum.
module k7_loader #(
   parameter logic [7:0]  INDEX       = 8'd1,
   parameter logic [24:0] MAX_LEN     = 25'h100000,
   parameter int          ACK_TIMEOUT = 16
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic [24:0] mem_addr,
   output logic [7:0]  mem_din,
   output logic        mem_we,
   input  logic        mem_ack,
   output logic [24:0] tape_len,
   output logic        tape_valid,
   output logic        load_done,
   output logic        overflow,
   output logic [7:0]  csum
);

   typedef enum logic [1:0] {IDLE, WRITE, FINISH} state_t;

   localparam int            TW    = $clog2(ACK_TIMEOUT + 1);
   // mem_we is held for at most ACK_TIMEOUT cycles when no ack arrives
   localparam logic [TW-1:0] TLAST = TW'(ACK_TIMEOUT - 1);

   state_t        state, state_d, cur;
   logic          dl_q, pend_fin, pend_fin_d;
   logic [TW-1:0] timer, timer_d;
   logic [24:0]   mem_addr_d, tape_len_d;
   logic [7:0]    mem_din_d;
   logic          mem_we_d, ioctl_wait_d, tape_valid_d, load_done_d, overflow_d;
   logic          sel, rise, fall;

   assign sel  = ioctl_download & (ioctl_index == INDEX);
   assign rise = sel & ~dl_q;
   assign fall = ~sel & dl_q;

`ifdef K7_LOADER_CSUM_EN
   logic [7:0] csum_q, csum_d;
   assign csum = csum_q;
`else
   assign csum = 8'h00;
`endif

   always_comb begin
      state_d      = state;
      pend_fin_d   = pend_fin;
      timer_d      = timer;
      mem_addr_d   = mem_addr;
      mem_din_d    = mem_din;
      mem_we_d     = mem_we;
      ioctl_wait_d = ioctl_wait;
      tape_len_d   = tape_len;
      tape_valid_d = tape_valid;
      load_done_d  = 1'b0;
      overflow_d   = overflow;
`ifdef K7_LOADER_CSUM_EN
      csum_d       = csum_q;
`endif
      cur          = state;

      // A new download restarts the image; a byte in the same cycle is still taken
      if (rise) begin
         cur          = IDLE;
         tape_valid_d = 1'b0;
         tape_len_d   = 25'd0;
         overflow_d   = 1'b0;
         pend_fin_d   = 1'b0;
`ifdef K7_LOADER_CSUM_EN
         csum_d       = 8'h00;
`endif
      end

      case (cur)
         IDLE: begin
            state_d      = IDLE;
            mem_we_d     = 1'b0;
            ioctl_wait_d = 1'b0;
            if (fall) begin
               state_d = FINISH;
            end else if (ioctl_wr && sel) begin
               if (ioctl_addr < MAX_LEN) begin
                  mem_addr_d   = ioctl_addr;
                  mem_din_d    = ioctl_dout;
                  mem_we_d     = 1'b1;
                  ioctl_wait_d = 1'b1;
                  timer_d      = '0;
                  state_d      = WRITE;
               end else begin
                  overflow_d = 1'b1;
               end
            end
         end
         WRITE: begin
            if (fall) pend_fin_d = 1'b1;
            if (mem_ack || (timer == TLAST)) begin
               mem_we_d     = 1'b0;
               ioctl_wait_d = 1'b0;
               if ((mem_addr + 25'd1) > tape_len) tape_len_d = mem_addr + 25'd1;
`ifdef K7_LOADER_CSUM_EN
               csum_d       = csum_q + mem_din;
`endif
               pend_fin_d   = 1'b0;
               state_d      = (pend_fin || fall) ? FINISH : IDLE;
            end else begin
               timer_d = timer + 1'b1;
            end
         end
         FINISH: begin
            tape_valid_d = (tape_len != 25'd0);
            load_done_d  = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         dl_q       <= 1'b0;
         pend_fin   <= 1'b0;
         timer      <= '0;
         mem_addr   <= 25'd0;
         mem_din    <= 8'h00;
         mem_we     <= 1'b0;
         ioctl_wait <= 1'b0;
         tape_len   <= 25'd0;
         tape_valid <= 1'b0;
         load_done  <= 1'b0;
         overflow   <= 1'b0;
`ifdef K7_LOADER_CSUM_EN
         csum_q     <= 8'h00;
`endif
      end else begin
         state      <= state_d;
         dl_q       <= sel;
         pend_fin   <= pend_fin_d;
         timer      <= timer_d;
         mem_addr   <= mem_addr_d;
         mem_din    <= mem_din_d;
         mem_we     <= mem_we_d;
         ioctl_wait <= ioctl_wait_d;
         tape_len   <= tape_len_d;
         tape_valid <= tape_valid_d;
         load_done  <= load_done_d;
         overflow   <= overflow_d;
`ifdef K7_LOADER_CSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_k7_loader.sv
// tb/tb_k7_loader.sv - directed bench for k7_loader (default and MAX_LEN=4 instances).
module tb_k7_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = 8'd0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = 25'd0;
   logic [7:0]  ioctl_dout = 8'd0;
   logic        mem_ack = 1'b0;

   logic        ioctl_wait, mem_we, tape_valid, load_done, overflow;
   logic [24:0] mem_addr, tape_len;
   logic [7:0]  mem_din, csum;
   logic        s_ioctl_wait, s_mem_we, s_tape_valid, s_load_done, s_overflow;
   logic [24:0] s_mem_addr, s_tape_len;
   logic [7:0]  s_mem_din, s_csum;

   int total = 0;
   int bad = 0;
   int wr_cnt = 0;
   int s_wr_cnt = 0;
   int ld_cnt = 0;
   logic mw_q = 1'b0;
   logic s_mw_q = 1'b0;

`ifdef K7_LOADER_CSUM_EN
   localparam logic [7:0] CS1 = 8'h3B, CS4 = 8'h33, CS6 = 8'h91;
`else
   localparam logic [7:0] CS1 = 8'h00, CS4 = 8'h00, CS6 = 8'h00;
`endif

   always #5 clk = ~clk;

   k7_loader dut (
      .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_ack(mem_ack),
      .tape_len(tape_len), .tape_valid(tape_valid), .load_done(load_done),
      .overflow(overflow), .csum(csum)
   );

   k7_loader #(.MAX_LEN(25'd4)) dut_small (
      .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(s_ioctl_wait),
      .mem_addr(s_mem_addr), .mem_din(s_mem_din), .mem_we(s_mem_we), .mem_ack(mem_ack),
      .tape_len(s_tape_len), .tape_valid(s_tape_valid), .load_done(s_load_done),
      .overflow(s_overflow), .csum(s_csum)
   );

   always @(posedge clk) begin
      mw_q   <= mem_we;
      s_mw_q <= s_mem_we;
      if (mem_we && !mw_q) wr_cnt <= wr_cnt + 1;
      if (s_mem_we && !s_mw_q) s_wr_cnt <= s_wr_cnt + 1;
      if (load_done) ld_cnt <= ld_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      @(negedge clk);
      ioctl_wr   = 1'b0;
   endtask

   // Byte write with mem_ack raised ack_dly cycles after mem_we appears
   task automatic send(input logic [24:0] a, input logic [7:0] d, input int ack_dly);
      int n;
      pulse(a, d);
      check("we_rise", mem_we, 1);
      check("mem_addr", mem_addr, a);
      check("mem_din", mem_din, d);
      n = 0;
      for (int i = 0; i < ack_dly; i++) begin
         if (ioctl_wait) n++;
         @(negedge clk);
      end
      mem_ack = 1'b1;
      if (ioctl_wait) n++;
      @(negedge clk);
      mem_ack = 1'b0;
      check("wait_cycles", n, ack_dly + 1);
      check("we_drop", mem_we, 0);
      check("wait_drop", ioctl_wait, 0);
   endtask

   task automatic start_dl(input logic [7:0] idx);
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      @(negedge clk);
   endtask

   task automatic end_dl;
      ioctl_download = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int w0, s0, l0, n;
      @(negedge clk);
      check("rst_we", mem_we, 0);
      check("rst_wait", ioctl_wait, 0);
      check("rst_len", tape_len, 0);
      check("rst_valid", tape_valid, 0);
      check("rst_ovf", overflow, 0);
      check("rst_csum", csum, 0);
      check("rst_done", load_done, 0);
      check("rst_addr", mem_addr, 0);
      reset = 1'b0;
      @(negedge clk);

      // basic three-byte image
      w0 = wr_cnt; l0 = ld_cnt;
      start_dl(8'd1);
      send(25'd0, 8'h3C, 2);
      send(25'd1, 8'h55, 2);
      send(25'd2, 8'hAA, 2);
      check("t1_valid_early", tape_valid, 0);
      end_dl;
      check("t1_writes", wr_cnt - w0, 3);
      check("t1_len", tape_len, 3);
      check("t1_valid", tape_valid, 1);
      check("t1_done", ld_cnt - l0, 1);
      check("t1_csum", csum, CS1);

      // other index is ignored
      w0 = wr_cnt; l0 = ld_cnt;
      start_dl(8'd0);
      for (int i = 0; i < 4; i++) begin
         pulse(25'(i), 8'hF0);
         check("t2_no_we", mem_we, 0);
         check("t2_no_wait", ioctl_wait, 0);
      end
      end_dl;
      check("t2_writes", wr_cnt - w0, 0);
      check("t2_len", tape_len, 3);
      check("t2_valid", tape_valid, 1);
      check("t2_csum", csum, CS1);
      check("t2_done", ld_cnt - l0, 0);

      // overflow on the MAX_LEN=4 instance
      s0 = s_wr_cnt;
      start_dl(8'd1);
      check("t3_clear_valid", tape_valid, 0);
      for (int i = 0; i < 6; i++) send(25'(i), 8'(i + 1), 2);
      end_dl;
      check("t3_s_writes", s_wr_cnt - s0, 4);
      check("t3_s_ovf", s_overflow, 1);
      check("t3_s_len", s_tape_len, 4);
      check("t3_s_valid", s_tape_valid, 1);
      check("t3_ovf", overflow, 0);
      check("t3_len", tape_len, 6);

      // ack timeout
      start_dl(8'd1);
      pulse(25'd0, 8'h11);
      n = 0;
      while (mem_we && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("t4_we_cycles", n, 16);
      check("t4_wait_rel", ioctl_wait, 0);
      send(25'd1, 8'h22, 1);
      end_dl;
      check("t4_len", tape_len, 2);
      check("t4_valid", tape_valid, 1);
      check("t4_csum", csum, CS4);

      // download ends while a write is outstanding
      start_dl(8'd1);
      pulse(25'd7, 8'h77);
      check("t5_we", mem_we, 1);
      ioctl_download = 1'b0;
      l0 = ld_cnt;
      @(negedge clk);
      @(negedge clk);
      mem_ack = 1'b1;
      check("t5_we_held", mem_we, 1);
      check("t5_no_done_yet", load_done, 0);
      check("t5_done_cnt0", ld_cnt - l0, 0);
      @(negedge clk);
      mem_ack = 1'b0;
      check("t5_we_drop", mem_we, 0);
      repeat (4) @(negedge clk);
      check("t5_done", ld_cnt - l0, 1);
      check("t5_len", tape_len, 8);
      check("t5_valid", tape_valid, 1);

      // asynchronous reset mid-write, then a fresh load
      start_dl(8'd1);
      pulse(25'd0, 8'h3C);
      check("t6_we", mem_we, 1);
      #1 reset = 1'b1;
      #1;
      check("t6_rst_we", mem_we, 0);
      check("t6_rst_wait", ioctl_wait, 0);
      check("t6_rst_valid", tape_valid, 0);
      check("t6_rst_len", tape_len, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      send(25'd0, 8'h3C, 2);
      send(25'd1, 8'h55, 2);
      end_dl;
      check("t6_len", tape_len, 2);
      check("t6_valid", tape_valid, 1);
      check("t6_csum", csum, CS6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/k7_loader.md
Name: k7_loader

Overview:
- Write-side staging block between hps_io's ioctl download port and the SDRAM controller.
- Captures .k7 tape bytes streamed from the HPS, writes each byte into SDRAM with a single-byte handshake, and back-pressures the HPS through ioctl_wait.
- Publishes tape length and a valid flag to the cassette player, which reads the image back from SDRAM.

Parameters:
- INDEX, 8'd1: ioctl_index value accepted as a tape image; all other indices are ignored.
- MAX_LEN, 25'h100000: maximum image size in bytes; bytes at address >= MAX_LEN are dropped.
- ACK_TIMEOUT, 16: cycles to wait for mem_ack before forcing completion of a write.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ioctl_download  in  1  HPS download active
- ioctl_index  in  8  download target index
- ioctl_wr  in  1  single-cycle byte strobe
- ioctl_addr  in  25  byte address of ioctl_dout
- ioctl_dout  in  8  download byte
- ioctl_wait  out  1  stall request to HPS
- mem_addr  out  25  SDRAM write address
- mem_din  out  8  SDRAM write data
- mem_we  out  1  SDRAM write request, level held until ack
- mem_ack  in  1  SDRAM write accepted, single cycle
- tape_len  out  25  image length in bytes (highest accepted addr + 1)
- tape_valid  out  1  complete image present
- load_done  out  1  one-cycle pulse at end of accepted download
- overflow  out  1  sticky: at least one byte dropped (addr >= MAX_LEN)
- csum  out  8  image checksum (see Optional Feature)

Behaviour:
- Reset, asynchronous, any state: state=IDLE; all outputs 0 (ioctl_wait, mem_we, mem_addr, mem_din, tape_len, tape_valid, load_done, overflow, csum).
- sel = ioctl_download & (ioctl_index == INDEX). dl_q = registered sel.
- Rising edge of sel (sel & ~dl_q): clear tape_valid, tape_len, overflow and csum; state=IDLE.
- States:
  - IDLE: on ioctl_wr & sel:
    - addr < MAX_LEN: latch mem_addr=ioctl_addr and mem_din=ioctl_dout; next cycle assert mem_we and ioctl_wait; go to WRITE.
    - addr >= MAX_LEN: set overflow; stay in IDLE; no SDRAM access.
  - WRITE: hold mem_we, ioctl_wait, mem_addr and mem_din stable. On mem_ack, or when the timeout counter reaches ACK_TIMEOUT, drop mem_we and ioctl_wait on the next edge.
    - tape_len = max(tape_len, mem_addr+1); 25-bit compare, no wrap since mem_addr < MAX_LEN.
    - Timeout counter is reset on entry to WRITE.
    - Return to IDLE.
  - FINISH: entered on falling edge of sel (~sel & dl_q) from IDLE. Set tape_valid = (tape_len != 0); pulse load_done for 1 cycle; return to IDLE.
- Falling edge of sel while in WRITE: complete the write first, then enter FINISH. The edge is latched in pend_fin.
- Latency: ioctl_wr to mem_we = 1 cycle. ioctl_wait is high from the cycle after ioctl_wr until the cycle after mem_ack.
- Strobe handling:
  - ioctl_wr arriving in WRITE (protocol violation) is ignored; no queueing.
  - ioctl_wr with ~sel (other index) is ignored entirely.
- mem_ack in IDLE is ignored.
- Download of a different index never alters tape_len, tape_valid or csum.
- Reset mid-WRITE: mem_we and ioctl_wait drop asynchronously; the image is invalid (tape_valid=0).

Optional Feature:
- Macro: K7_LOADER_CSUM_EN.
- Defined: csum = 8-bit modulo-256 sum of every byte written to SDRAM. Updated on mem_ack, or on timeout completion. Dropped bytes are excluded. Cleared on the sel rising edge.
- Undefined: csum is tied to 8'h00 and no adder is synthesised.

Test Plan:
- Download idx 1, bytes 0x3C,0x55,0xAA at addr 0..2, mem_ack 2 cycles after each mem_we -> three SDRAM writes with matching addr/data; ioctl_wait high 3 cycles each; after download falls, tape_len=3, tape_valid=1, load_done 1 cycle; csum=0x3B with macro, 0 without.
- Download idx 0 with 4 bytes -> no mem_we, ioctl_wait stays 0, tape_len/tape_valid unchanged from prior load.
- MAX_LEN=4, bytes at addr 0..5 -> 4 writes, overflow=1, tape_len=4, tape_valid=1.
- mem_ack never asserted -> mem_we drops after ACK_TIMEOUT=16 cycles, ioctl_wait releases, FSM returns to IDLE, tape_len still updated.
- ioctl_download falls during WRITE of addr 7 -> write completes on ack, then load_done pulses, tape_len=8.
- Assert reset while mem_we=1 -> mem_we, ioctl_wait, tape_valid and tape_len read 0 in the same cycle; a new download then loads normally.
